// File: rtl/bus_read_arbiter.sv
// Round-robin arbiter sharing one memory read port between instruction and data reads.
// One read in flight: grant -> address phase -> data phase. Memory stalls and owner back-pressure hold the current phase.
module bus_read_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ir_addr_valid,
  output logic                 ir_addr_ready,
  input  logic [BUS_WIDTH-1:0] ir_addr,
  output logic                 ir_data_valid,
  input  logic                 ir_data_ready,
  output logic [BUS_WIDTH-1:0] ir_data,
  input  logic                 dr_addr_valid,
  output logic                 dr_addr_ready,
  input  logic [BUS_WIDTH-1:0] dr_addr,
  output logic                 dr_data_valid,
  input  logic                 dr_data_ready,
  output logic [BUS_WIDTH-1:0] dr_data,
  output logic                 mem_addr_valid,
  input  logic                 mem_addr_ready,
  output logic [BUS_WIDTH-1:0] mem_addr,
  input  logic                 mem_data_valid,
  output logic                 mem_data_ready,
  input  logic [BUS_WIDTH-1:0] mem_data,
  output logic [CNT_WIDTH-1:0] ir_count,
  output logic [CNT_WIDTH-1:0] dr_count
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {IR, DR} req_t;

  state_t               state, state_nxt;
  req_t                 owner, last;
  logic [BUS_WIDTH-1:0] addr_q;
  logic                 grant_ir, grant_dr;
  logic                 data_hs;

  // On a tie the requester that did not win last time gets the port.
  assign grant_ir = ir_addr_valid && (!dr_addr_valid || last == DR);
  assign grant_dr = dr_addr_valid && !grant_ir;
  assign data_hs  = (state == DATA) && mem_data_valid && mem_data_ready;

  assign mem_addr = addr_q;
  assign ir_data  = (owner == IR) ? mem_data : '0;
  assign dr_data  = (owner == DR) ? mem_data : '0;

  // Every handshake output is gated by rst so nothing is accepted or forwarded in a reset cycle.
  always_comb begin
    state_nxt      = state;
    ir_addr_ready  = 1'b0;
    dr_addr_ready  = 1'b0;
    mem_addr_valid = 1'b0;
    mem_data_ready = 1'b0;
    ir_data_valid  = 1'b0;
    dr_data_valid  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          ir_addr_ready = grant_ir;
          dr_addr_ready = grant_dr;
          if (grant_ir || grant_dr) state_nxt = ADDR;
        end
        ADDR: begin
          mem_addr_valid = 1'b1;
          if (mem_addr_ready) state_nxt = DATA;
        end
        DATA: begin
          mem_data_ready = (owner == IR) ? ir_data_ready : dr_data_ready;
          ir_data_valid  = (owner == IR) && mem_data_valid;
          dr_data_valid  = (owner == DR) && mem_data_valid;
          if (mem_data_valid && mem_data_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= IR;
      last     <= DR;
      addr_q   <= '0;
      ir_count <= '0;
      dr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (grant_ir || grant_dr)) begin
        addr_q <= grant_ir ? ir_addr : dr_addr;
        owner  <= grant_ir ? IR : DR;
      end
      if (data_hs) begin
        last <= owner;
        if (owner == IR) ir_count <= ir_count + 1'b1;
        else             dr_count <= dr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Directed bench for bus_read_arbiter: reset, contention, single read, memory stall, back-pressure, reset mid-read.
module tb_bus_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
  logic [31:0] ir_addr, ir_data;
  logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
  logic [31:0] dr_addr, dr_data;
  logic        mem_addr_valid, mem_addr_ready, mem_data_valid, mem_data_ready;
  logic [31:0] mem_addr, mem_data;
  logic [15:0] ir_count, dr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_read_arbiter #(.BUS_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
    .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
    .ir_count(ir_count), .dr_count(dr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ir_addr_valid = 1'b1; dr_addr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ir_addr_ready, dr_addr_ready, mem_addr_valid, mem_data_ready, ir_data_valid, dr_data_valid} !== 6'b0) begin
        errors++;
        $display("FAIL reset_handshakes cycle %0d got %b required 000000", i,
                 {ir_addr_ready, dr_addr_ready, mem_addr_valid, mem_data_ready, ir_data_valid, dr_data_valid});
      end
      checks++;
      if (ir_count !== 16'd0 || dr_count !== 16'd0) begin
        errors++;
        $display("FAIL reset_counts got %0d/%0d required 0/0", ir_count, dr_count);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ir_addr_ready !== 1'b1 || dr_addr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_tie got ir=%b dr=%b required ir=1 dr=0", ir_addr_ready, dr_addr_ready);
    end
    ir_addr_valid = 1'b0; dr_addr_valid = 1'b0;
    #1;
    checks++;
    if (ir_addr_ready !== 1'b0 || mem_addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got ir_rdy=%b mav=%b required 0 0", ir_addr_ready, mem_addr_valid);
    end
    tick();
  endtask

  task automatic test_contention();
    logic        exp_ir;
    logic [31:0] exp_addr, exp_data;
    ir_data_ready = 1'b1; dr_data_ready = 1'b1; mem_addr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_ir   = (k % 2 == 0);
      exp_addr = exp_ir ? 32'(4 * (k / 2)) : 32'(32'h8000 + 4 * (k / 2));
      exp_data = 32'hA000_0000 + 32'(k);
      ir_addr_valid = 1'b1; dr_addr_valid = 1'b1;
      ir_addr = 32'(4 * (k / 2)); dr_addr = 32'(32'h8000 + 4 * (k / 2));
      #1;
      checks++;
      if (ir_addr_ready !== exp_ir || dr_addr_ready !== !exp_ir) begin
        errors++;
        $display("FAIL contention_grant %0d got ir=%b dr=%b required ir=%b", k, ir_addr_ready, dr_addr_ready, exp_ir);
      end
      tick();
      checks++;
      if (mem_addr_valid !== 1'b1 || mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL contention_addr %0d got v=%b a=%h required v=1 a=%h", k, mem_addr_valid, mem_addr, exp_addr);
      end
      tick();
      mem_data_valid = 1'b1; mem_data = exp_data;
      #1;
      checks++;
      if (exp_ir ? (ir_data_valid !== 1'b1 || ir_data !== exp_data || dr_data_valid !== 1'b0)
                 : (dr_data_valid !== 1'b1 || dr_data !== exp_data || ir_data_valid !== 1'b0)) begin
        errors++;
        $display("FAIL contention_route %0d got irv=%b ird=%h drv=%b drd=%h required data %h to %s",
                 k, ir_data_valid, ir_data, dr_data_valid, dr_data, exp_data, exp_ir ? "ir" : "dr");
      end
      checks++;
      if (ir_addr_ready !== 1'b0 || dr_addr_ready !== 1'b0) begin
        errors++;
        $display("FAIL contention_no_grant_in_data %0d got ir=%b dr=%b required 0 0", k, ir_addr_ready, dr_addr_ready);
      end
      tick();
      mem_data_valid = 1'b0;
    end
    ir_addr_valid = 1'b0; dr_addr_valid = 1'b0;
    #1;
    checks++;
    if (ir_count !== 16'd2 || dr_count !== 16'd2) begin
      errors++;
      $display("FAIL contention_counts got %0d/%0d required 2/2", ir_count, dr_count);
    end
  endtask

  task automatic test_single_ir();
    ir_addr_valid = 1'b1; ir_addr = 32'h100; mem_addr_ready = 1'b1;
    #1;
    checks++;
    if (ir_addr_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got %b required 1", ir_addr_ready);
    end
    tick();
    ir_addr_valid = 1'b0; ir_addr = 32'h555;
    #1;
    checks++;
    if (mem_addr_valid !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL single_addr got v=%b a=%h required v=1 a=00000100", mem_addr_valid, mem_addr);
    end
    tick();
    mem_data_valid = 1'b1; mem_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (ir_data_valid !== 1'b1 || ir_data !== 32'hDEADBEEF || dr_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_data got irv=%b ird=%h drv=%b required 1 deadbeef 0", ir_data_valid, ir_data, dr_data_valid);
    end
    tick();
    mem_data_valid = 1'b0;
    #1;
    checks++;
    if (ir_count !== 16'd3 || dr_count !== 16'd2 || mem_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_count got %0d/%0d mdr=%b required 3/2 mdr=0", ir_count, dr_count, mem_data_ready);
    end
  endtask

  task automatic test_mem_stall();
    int hs = 0;
    ir_addr_valid = 1'b1; ir_addr = 32'h200; mem_addr_ready = 1'b0;
    #1;
    checks++;
    if (ir_addr_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_grant got %b required 1", ir_addr_ready);
    end
    tick();
    ir_addr_valid = 1'b0; ir_addr = 32'hFFFF; dr_addr_valid = 1'b1; dr_addr = 32'h300;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (mem_addr_valid !== 1'b1 || mem_addr !== 32'h200 || dr_addr_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_addr_hold %0d got v=%b a=%h drr=%b required 1 00000200 0", i, mem_addr_valid, mem_addr, dr_addr_ready);
      end
      tick();
    end
    mem_addr_ready = 1'b1;
    tick();
    mem_addr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_data_valid = (i == 4); mem_data = 32'h12345678;
      #1;
      if (mem_data_valid && mem_data_ready) hs++;
      checks++;
      if (ir_data_valid !== mem_data_valid || dr_addr_ready !== 1'b0 || mem_addr_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_data %0d got irv=%b drr=%b mav=%b required %b 0 0", i, ir_data_valid, dr_addr_ready, mem_addr_valid, mem_data_valid);
      end
      tick();
    end
    mem_data_valid = 1'b0;
    #1;
    checks++;
    if (hs !== 1 || ir_count !== 16'd4) begin
      errors++;
      $display("FAIL stall_one_handshake got hs=%0d ir_count=%0d required 1 4", hs, ir_count);
    end
  endtask

  task automatic test_backpressure();
    // DR has been waiting since the stall test and is the sole requester in IDLE.
    dr_data_ready = 1'b0; mem_addr_ready = 1'b1;
    checks++;
    if (dr_addr_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_grant got %b required 1", dr_addr_ready);
    end
    tick();
    dr_addr_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_data_valid = (i != 1); mem_data = 32'hCAFEF00D;
      #1;
      checks++;
      if (mem_data_ready !== 1'b0 || dr_data_valid !== mem_data_valid || dr_data !== 32'hCAFEF00D || mem_addr_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold %0d got mdr=%b drv=%b drd=%h mav=%b required 0 %b cafef00d 0",
                 i, mem_data_ready, dr_data_valid, dr_data, mem_addr_valid, mem_data_valid);
      end
      tick();
    end
    dr_data_ready = 1'b1; mem_data_valid = 1'b1;
    #1;
    checks++;
    if (mem_data_ready !== 1'b1 || dr_data_valid !== 1'b1 || dr_count !== 16'd2) begin
      errors++;
      $display("FAIL bp_release got mdr=%b drv=%b cnt=%0d required 1 1 2", mem_data_ready, dr_data_valid, dr_count);
    end
    tick();
    mem_data_valid = 1'b0;
    #1;
    checks++;
    if (dr_count !== 16'd3 || mem_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_done got cnt=%0d mdr=%b required 3 0", dr_count, mem_data_ready);
    end
  endtask

  task automatic test_reset_mid_data();
    ir_addr_valid = 1'b1; ir_addr = 32'h400; mem_addr_ready = 1'b1;
    tick();
    ir_addr_valid = 1'b0;
    tick();
    mem_data_valid = 1'b1; mem_data = 32'h0BAD0BAD; rst = 1'b1;
    #1;
    checks++;
    if (ir_data_valid !== 1'b0 || dr_data_valid !== 1'b0 || mem_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_forward got irv=%b drv=%b mdr=%b required 0 0 0", ir_data_valid, dr_data_valid, mem_data_ready);
    end
    tick();
    rst = 1'b0; mem_data_valid = 1'b0;
    #1;
    checks++;
    if (ir_count !== 16'd0 || dr_count !== 16'd0 || mem_addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_counts got %0d/%0d mav=%b required 0/0 0", ir_count, dr_count, mem_addr_valid);
    end
    ir_addr_valid = 1'b1; dr_addr_valid = 1'b1;
    #1;
    checks++;
    if (ir_addr_ready !== 1'b1 || dr_addr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle_tie got ir=%b dr=%b required 1 0", ir_addr_ready, dr_addr_ready);
    end
    ir_addr_valid = 1'b0; dr_addr_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ir_addr_valid = 1'b0; ir_addr = '0; ir_data_ready = 1'b1;
    dr_addr_valid = 1'b0; dr_addr = '0; dr_data_ready = 1'b1;
    mem_addr_ready = 1'b0; mem_data_valid = 1'b0; mem_data = '0;
    test_reset();
    test_contention();
    test_single_ir();
    test_mem_stall();
    test_backpressure();
    test_reset_mid_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
